// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU operations, datapath select values and FSM state encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // AND is zero so that an all-zero control word is also the idle ALU op
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_RS = 1'b1;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEMADDR   = 4'd3;
  localparam logic [3:0] S_MEMREAD   = 4'd4;
  localparam logic [3:0] S_MEMWB     = 4'd5;
  localparam logic [3:0] S_MEMWRITE  = 4'd6;
  localparam logic [3:0] S_EXEC      = 4'd7;
  localparam logic [3:0] S_ALUWB     = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;

  typedef struct packed {
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_we;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       rd_en;
    logic       rd_sel;
    logic       rd_data_sel;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the control FSM (master) and memory (slave).
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; anything unrecognised falls back to AND.
module alu_decoder
  import mips_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          funct_i,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_OP_W'(ALU_AND);
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_OP_W'(ALU_ADD);
      FN_SUB:  alu_op_o = ALU_OP_W'(ALU_SUB);
      FN_AND:  alu_op_o = ALU_OP_W'(ALU_AND);
      FN_OR:   alu_op_o = ALU_OP_W'(ALU_OR);
      FN_SLT:  alu_op_o = ALU_OP_W'(ALU_SLT);
      default: alu_op_o = ALU_OP_W'(ALU_AND);
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset (R-type, ADDI, LW, SW, BEQ, J).
// Outputs decode from the state register, so reset forces them to zero at once.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  input  logic                alu_zero_i,
  input  logic                mem_ready_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          pc_src_o,
  output logic                pc_we_o,
  output logic                ir_we_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                iord_o,
  output logic                rd_en_o,
  output logic                rd_sel_o,
  output logic                rd_data_sel_o,
  output logic                illegal_o,
  output logic [3:0]          state_o
);

  logic [3:0]          state_q, state_d;
  logic [ALU_OP_W-1:0] funct_op;
  logic [ALU_OP_W-1:0] alu_op;
  logic                op_valid;
  ctrl_t               ctl;

  multicycle_control_if mem_bus ();

  assign mem_bus.mem_ready = mem_ready_i;
  assign mem_bus.mem_req   = ctl.mem_req;
  assign mem_bus.mem_we    = ctl.mem_we;
  assign mem_bus.iord      = ctl.iord;

  alu_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_decoder (
    .funct_i  (funct_i),
    .alu_op_o (funct_op)
  );

  always_comb begin
    op_valid = 1'b0;
    case (opcode_i)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: op_valid = 1'b1;
      OP_J:                                    op_valid = ENABLE_JUMP;
      default:                                 op_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = ENABLE_JUMP ? S_JUMP : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR still holds the opcode, so it selects the load or store leg here
      S_MEMADDR:   state_d = (opcode_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:   if (mem_bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE:  if (mem_bus.mem_ready) state_d = S_FETCH;
      S_EXEC:      state_d = S_ALUWB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEMWB, S_ALUWB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl    = '0;
    alu_op = ALU_OP_W'(ALU_AND);
    case (state_q)
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        ctl.src_a   = SRCA_PC;
        ctl.src_b   = SRCB_FOUR;
        ctl.pc_src  = PCSRC_ALU;
        ctl.pc_we   = mem_bus.mem_ready;
        ctl.ir_we   = mem_bus.mem_ready;
        alu_op      = ALU_OP_W'(ALU_ADD);
      end
      S_DECODE: begin
        // speculative branch target lands in ALUOut for BRANCH to use
        ctl.src_a   = SRCA_PC;
        ctl.src_b   = SRCB_IMM_SH2;
        ctl.illegal = ~op_valid;
        alu_op      = ALU_OP_W'(ALU_ADD);
      end
      S_MEMADDR, S_ADDI_EXEC: begin
        ctl.src_a = SRCA_RS;
        ctl.src_b = SRCB_IMM;
        alu_op    = ALU_OP_W'(ALU_ADD);
      end
      S_MEMREAD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctl.rd_en       = 1'b1;
        ctl.rd_data_sel = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.iord    = 1'b1;
      end
      S_EXEC: begin
        ctl.src_a = SRCA_RS;
        ctl.src_b = SRCB_RT;
        alu_op    = funct_op;
      end
      S_ALUWB: begin
        ctl.rd_en  = 1'b1;
        ctl.rd_sel = 1'b1;
      end
      S_ADDI_WB: ctl.rd_en = 1'b1;
      S_BRANCH: begin
        ctl.src_a  = SRCA_RS;
        ctl.src_b  = SRCB_RT;
        ctl.pc_src = PCSRC_ALUOUT;
        ctl.pc_we  = alu_zero_i;
        alu_op     = ALU_OP_W'(ALU_SUB);
      end
      S_JUMP: begin
        ctl.pc_src = PCSRC_JUMP;
        ctl.pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign alu_op_o      = alu_op;
  assign alu_src_a_o   = ctl.src_a;
  assign alu_src_b_o   = ctl.src_b;
  assign pc_src_o      = ctl.pc_src;
  assign pc_we_o       = ctl.pc_we;
  assign ir_we_o       = ctl.ir_we;
  assign mem_req_o     = mem_bus.mem_req;
  assign mem_we_o      = mem_bus.mem_we;
  assign iord_o        = mem_bus.iord;
  assign rd_en_o       = ctl.rd_en;
  assign rd_sel_o      = ctl.rd_sel;
  assign rd_data_sel_o = ctl.rd_data_sel;
  assign illegal_o     = ctl.illegal;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: each driven cycle pushes the full expected control word,
// the negedge monitor pops it and compares against the DUT.
module tb_multicycle_control;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] op;
    logic       a;
    logic [1:0] b;
    logic [1:0] ps;
    logic [8:0] fl;
  } obs_t;

  typedef struct {
    string tag;
    bit    d2;
    obs_t  v;
  } sbe_t;

  localparam logic [8:0] F_PCWE  = 9'h100;
  localparam logic [8:0] F_IRWE  = 9'h080;
  localparam logic [8:0] F_MREQ  = 9'h040;
  localparam logic [8:0] F_MWE   = 9'h020;
  localparam logic [8:0] F_IORD  = 9'h010;
  localparam logic [8:0] F_RDEN  = 9'h008;
  localparam logic [8:0] F_RDSEL = 9'h004;
  localparam logic [8:0] F_RDDS  = 9'h002;
  localparam logic [8:0] F_ILL   = 9'h001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero;

  always #5 clk = ~clk;

  multicycle_control_if mif ();

  logic [3:0] op1, op2, st1, st2;
  logic       a1, a2;
  logic [1:0] b1, b2, ps1, ps2;
  logic       pcwe1, irwe1, mreq1, mwe1, iord1, rden1, rdsel1, rdds1, ill1;
  logic       pcwe2, irwe2, mreq2, mwe2, iord2, rden2, rdsel2, rdds2, ill2;

  assign mif.mem_req = mreq1;
  assign mif.mem_we  = mwe1;
  assign mif.iord    = iord1;

  multicycle_control #(.ALU_OP_W(4), .ENABLE_JUMP(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .funct_i(funct),
    .alu_zero_i(alu_zero), .mem_ready_i(mif.mem_ready),
    .alu_op_o(op1), .alu_src_a_o(a1), .alu_src_b_o(b1), .pc_src_o(ps1),
    .pc_we_o(pcwe1), .ir_we_o(irwe1), .mem_req_o(mreq1), .mem_we_o(mwe1),
    .iord_o(iord1), .rd_en_o(rden1), .rd_sel_o(rdsel1), .rd_data_sel_o(rdds1),
    .illegal_o(ill1), .state_o(st1)
  );

  // second instance with jumps disabled, permanently fed a J opcode
  multicycle_control #(.ALU_OP_W(4), .ENABLE_JUMP(1'b0)) dut_nj (
    .clk_i(clk), .rst_n_i(rst_n), .opcode_i(OP_J), .funct_i(6'h00),
    .alu_zero_i(1'b0), .mem_ready_i(1'b1),
    .alu_op_o(op2), .alu_src_a_o(a2), .alu_src_b_o(b2), .pc_src_o(ps2),
    .pc_we_o(pcwe2), .ir_we_o(irwe2), .mem_req_o(mreq2), .mem_we_o(mwe2),
    .iord_o(iord2), .rd_en_o(rden2), .rd_sel_o(rdsel2), .rd_data_sel_o(rdds2),
    .illegal_o(ill2), .state_o(st2)
  );

  obs_t obs1, obs2;
  assign obs1 = {st1, op1, a1, b1, ps1,
                 {pcwe1, irwe1, mreq1, mwe1, iord1, rden1, rdsel1, rdds1, ill1}};
  assign obs2 = {st2, op2, a2, b2, ps2,
                 {pcwe2, irwe2, mreq2, mwe2, iord2, rden2, rdsel2, rdds2, ill2}};

  int   checks = 0;
  int   failures = 0;
  sbe_t sb[$];
  sbe_t cur;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t e(logic [3:0] st, logic [3:0] op, logic a,
                             logic [1:0] b, logic [1:0] ps, logic [8:0] fl);
    return {st, op, a, b, ps, fl};
  endfunction

  function automatic logic [3:0] fop(logic [5:0] f);
    case (f)
      6'h20:   return ALU_ADD;
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h2A:   return ALU_SLT;
      default: return ALU_AND;
    endcase
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk(cur.tag, cur.d2 ? obs2 : obs1, cur.v);
    end
  end

  // drive one cycle's inputs just after the edge and queue what that cycle must show
  task automatic cyc(string tag, bit rdy, bit z, obs_t v, bit d2 = 1'b0);
    mif.mem_ready = rdy;
    alu_zero      = z;
    sb.push_back('{tag, d2, v});
    @(posedge clk); #1;
  endtask

  task automatic run(string tag, logic [5:0] op, logic [5:0] fn, int fw, int mw, bit z);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fw; i++)
      cyc($sformatf("%s_fwait%0d", tag, i), 1'b0, z, e(S_FETCH, ALU_ADD, 1'b0, 2'd1, 2'd0, F_MREQ));
    cyc({tag, "_fetch"}, 1'b1, z, e(S_FETCH, ALU_ADD, 1'b0, 2'd1, 2'd0, F_PCWE | F_IRWE | F_MREQ));
    case (op)
      OP_RTYPE: begin
        cyc({tag, "_dec"}, 1'b1, z, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, 9'h0));
        cyc({tag, "_exec"}, 1'b1, z, e(S_EXEC, fop(fn), 1'b1, 2'd0, 2'd0, 9'h0));
        cyc({tag, "_wb"}, 1'b1, z, e(S_ALUWB, ALU_AND, 1'b0, 2'd0, 2'd0, F_RDEN | F_RDSEL));
      end
      OP_ADDI: begin
        cyc({tag, "_dec"}, 1'b1, z, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, 9'h0));
        cyc({tag, "_exec"}, 1'b1, z, e(S_ADDI_EXEC, ALU_ADD, 1'b1, 2'd2, 2'd0, 9'h0));
        cyc({tag, "_wb"}, 1'b1, z, e(S_ADDI_WB, ALU_AND, 1'b0, 2'd0, 2'd0, F_RDEN));
      end
      OP_LW: begin
        cyc({tag, "_dec"}, 1'b1, z, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, 9'h0));
        cyc({tag, "_addr"}, 1'b1, z, e(S_MEMADDR, ALU_ADD, 1'b1, 2'd2, 2'd0, 9'h0));
        for (int i = 0; i < mw; i++)
          cyc($sformatf("%s_rwait%0d", tag, i), 1'b0, z, e(S_MEMREAD, ALU_AND, 1'b0, 2'd0, 2'd0, F_MREQ | F_IORD));
        cyc({tag, "_rd"}, 1'b1, z, e(S_MEMREAD, ALU_AND, 1'b0, 2'd0, 2'd0, F_MREQ | F_IORD));
        cyc({tag, "_wb"}, 1'b1, z, e(S_MEMWB, ALU_AND, 1'b0, 2'd0, 2'd0, F_RDEN | F_RDDS));
      end
      OP_SW: begin
        cyc({tag, "_dec"}, 1'b1, z, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, 9'h0));
        cyc({tag, "_addr"}, 1'b1, z, e(S_MEMADDR, ALU_ADD, 1'b1, 2'd2, 2'd0, 9'h0));
        for (int i = 0; i < mw; i++)
          cyc($sformatf("%s_wwait%0d", tag, i), 1'b0, z, e(S_MEMWRITE, ALU_AND, 1'b0, 2'd0, 2'd0, F_MREQ | F_MWE | F_IORD));
        cyc({tag, "_wr"}, 1'b1, z, e(S_MEMWRITE, ALU_AND, 1'b0, 2'd0, 2'd0, F_MREQ | F_MWE | F_IORD));
      end
      OP_BEQ: begin
        cyc({tag, "_dec"}, 1'b1, z, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, 9'h0));
        cyc({tag, "_br"}, 1'b1, z, e(S_BRANCH, ALU_SUB, 1'b1, 2'd0, 2'd1, z ? F_PCWE : 9'h0));
      end
      OP_J: begin
        cyc({tag, "_dec"}, 1'b1, z, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, 9'h0));
        cyc({tag, "_jmp"}, 1'b1, z, e(S_JUMP, ALU_AND, 1'b0, 2'd0, 2'd2, F_PCWE));
      end
      default:
        cyc({tag, "_dec"}, 1'b1, z, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, F_ILL));
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    obs_t zero_w;
    zero_w        = '0;
    rst_n         = 1'b0;
    opcode        = 6'h00;
    funct         = 6'h00;
    alu_zero      = 1'b0;
    mif.mem_ready = 1'b0;
    @(posedge clk); #1;

    cyc("rst0", 1'b0, 1'b0, zero_w);
    cyc("rst1", 1'b1, 1'b1, zero_w);
    rst_n = 1'b1;
    cyc("rel_idle", 1'b1, 1'b0, zero_w);

    run("add",   OP_RTYPE, 6'h20, 0, 0, 1'b1);
    run("sub",   OP_RTYPE, 6'h22, 1, 0, 1'b0);
    run("and",   OP_RTYPE, 6'h24, 0, 0, 1'b0);
    run("or",    OP_RTYPE, 6'h25, 0, 0, 1'b0);
    run("slt",   OP_RTYPE, 6'h2A, 0, 0, 1'b0);
    run("fnbad", OP_RTYPE, 6'h3F, 0, 0, 1'b0);
    run("addi",  OP_ADDI,  6'h00, 0, 0, 1'b0);
    run("lw",    OP_LW,    6'h00, 2, 3, 1'b0);
    run("lw0",   OP_LW,    6'h00, 0, 0, 1'b0);
    run("sw",    OP_SW,    6'h00, 0, 2, 1'b0);
    run("beqz",  OP_BEQ,   6'h00, 0, 0, 1'b1);
    run("beqnz", OP_BEQ,   6'h00, 0, 0, 1'b0);
    run("j",     OP_J,     6'h00, 0, 0, 1'b0);
    run("ill3f", OP_RTYPE | 6'h3F, 6'h00, 0, 0, 1'b0);
    run("ill01", 6'h01,    6'h20, 0, 0, 1'b0);

    // store abandoned by a reset that lands mid-cycle while memory stalls
    opcode = OP_SW;
    cyc("swr_fetch", 1'b1, 1'b0, e(S_FETCH, ALU_ADD, 1'b0, 2'd1, 2'd0, F_PCWE | F_IRWE | F_MREQ));
    cyc("swr_dec",   1'b1, 1'b0, e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, 9'h0));
    cyc("swr_addr",  1'b1, 1'b0, e(S_MEMADDR, ALU_ADD, 1'b1, 2'd2, 2'd0, 9'h0));
    cyc("swr_wait0", 1'b0, 1'b0, e(S_MEMWRITE, ALU_AND, 1'b0, 2'd0, 2'd0, F_MREQ | F_MWE | F_IORD));
    mif.mem_ready = 1'b0;
    sb.push_back('{"swr_wait1", 1'b0, e(S_MEMWRITE, ALU_AND, 1'b0, 2'd0, 2'd0, F_MREQ | F_MWE | F_IORD)});
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", obs1, zero_w);
    @(posedge clk); #1;
    cyc("swr_rst_hold", 1'b0, 1'b0, zero_w);
    rst_n = 1'b1;
    cyc("swr_rel_idle", 1'b0, 1'b0, zero_w);
    cyc("swr_refetch", 1'b0, 1'b0, e(S_FETCH, ALU_ADD, 1'b0, 2'd1, 2'd0, F_MREQ));
    run("post_rst_add", OP_RTYPE, 6'h20, 0, 0, 1'b0);

    // jump-disabled instance: J must look exactly like an illegal opcode
    rst_n = 1'b0;
    cyc("nj_rst", 1'b1, 1'b0, zero_w, 1'b1);
    rst_n = 1'b1;
    cyc("nj_rel_idle", 1'b1, 1'b0, zero_w, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc($sformatf("nj_fetch%0d", k), 1'b1, 1'b0,
          e(S_FETCH, ALU_ADD, 1'b0, 2'd1, 2'd0, F_PCWE | F_IRWE | F_MREQ), 1'b1);
      cyc($sformatf("nj_dec%0d", k), 1'b1, 1'b0,
          e(S_DECODE, ALU_ADD, 1'b0, 2'd3, 2'd0, F_ILL), 1'b1);
    end
    cyc("nj_fetch2", 1'b1, 1'b0, e(S_FETCH, ALU_ADD, 1'b0, 2'd1, 2'd0, F_PCWE | F_IRWE | F_MREQ), 1'b1);

    @(negedge clk); #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter ALU_OP_W, default 4: width of alu_op_o.
REQ-002 The block SHALL have parameter ENABLE_JUMP, default 1: when 0, J (opcode 0x02) decodes as illegal.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port opcode_i, input, 6 bits: instruction-register opcode field.
REQ-006 The block SHALL have port funct_i, input, 6 bits: instruction-register funct field.
REQ-007 The block SHALL have port alu_zero_i, input, 1 bit: ALU result is zero.
REQ-008 The block SHALL have port mem_ready_i, input, 1 bit: memory completes the current request this cycle.
REQ-009 The block SHALL have port alu_op_o, output, ALU_OP_W bits: ALU operation.
REQ-010 The block SHALL have port alu_src_a_o, output, 1 bit: ALU operand A select, 0=PC, 1=rs.
REQ-011 The block SHALL have port alu_src_b_o, output, 2 bits: ALU operand B select, 0=rt, 1=const 4, 2=imm, 3=imm<<2.
REQ-012 The block SHALL have port pc_src_o, output, 2 bits: PC source, 0=ALU, 1=ALUOut register, 2=jump target.
REQ-013 The block SHALL have outputs pc_we_o, ir_we_o, mem_req_o, mem_we_o, iord_o, rd_en_o, rd_sel_o and rd_data_sel_o, 1 bit each: PC write, IR write, memory request, memory write, address select (0=PC, 1=ALUOut), register-file write, destination select (0=rt, 1=rd) and write-data select (0=ALU, 1=memory).
REQ-014 The block SHALL have output illegal_o, 1 bit: one-cycle pulse when an undefined opcode is decoded.
REQ-015 The block SHALL have output state_o, 4 bits: current state encoding, for debug.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP; only pc_we_o, ir_we_o and the FETCH/MEMREAD/MEMWRITE exits depend on inputs.
REQ-017 In IDLE the block SHALL drive all strobes to 0 and SHALL go to FETCH unconditionally.
REQ-018 In FETCH the block SHALL hold mem_req_o=1 and iord_o=0 until mem_ready_i=1; in that cycle ir_we_o=1, pc_we_o=1, A=PC, B=4, ADD, pc_src=0, and the next state is DECODE.
REQ-019 In DECODE the block SHALL set A=PC, B=imm<<2, ADD (branch target into ALUOut).
REQ-020 From DECODE the block SHALL go to MEMADDR on LW (0x23) or SW (0x2B), EXEC on R-type (0x00), ADDI_EXEC on ADDI (0x08), BRANCH on BEQ (0x04) and JUMP on J (0x02) when ENABLE_JUMP=1.
REQ-021 On any other opcode in DECODE the block SHALL pulse illegal_o=1 and go to FETCH.
REQ-022 In MEMADDR the block SHALL set A=rs, B=imm, ADD, then go to MEMREAD on LW and MEMWRITE on SW.
REQ-023 In MEMREAD the block SHALL hold mem_req_o=1, iord_o=1, mem_we_o=0 until mem_ready_i, then go to MEMWB.
REQ-024 In MEMWB the block SHALL assert rd_en_o=1 with rd_sel_o=0 and rd_data_sel_o=1, then go to FETCH.
REQ-025 In MEMWRITE the block SHALL hold mem_req_o=1, mem_we_o=1, iord_o=1 until mem_ready_i, then go to FETCH.
REQ-026 In EXEC the block SHALL set A=rs, B=rt, alu_op from funct (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, other=AND), then go to ALUWB.
REQ-027 In ALUWB the block SHALL assert rd_en_o=1 with rd_sel_o=1 and rd_data_sel_o=0, then go to FETCH.
REQ-028 The block SHALL execute ADDI as ADDI_EXEC (A=rs, B=imm, ADD) followed by ADDI_WB (rd_en_o=1, rd_sel_o=0, rd_data_sel_o=0), then go to FETCH.
REQ-029 In BRANCH the block SHALL set A=rs, B=rt, SUB, pc_src=1 and pc_we_o=alu_zero_i, then go to FETCH.
REQ-030 In JUMP the block SHALL set pc_src=2 and pc_we_o=1, then go to FETCH.
REQ-031 With zero wait states, the cycles from FETCH entry to the next FETCH entry SHALL be: R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3, illegal 2; each mem_ready_i=0 cycle in FETCH/MEMREAD/MEMWRITE SHALL add one cycle.
REQ-032 mem_req_o SHALL remain asserted with a stable address select and mem_we_o while waiting, and SHALL never be asserted for more than one request at a time.
REQ-033 Unused outputs in each state SHALL be 0; alu_op_o SHALL default to AND.

Reset
REQ-034 When rst_n_i=0 the block SHALL immediately enter IDLE, asynchronously and regardless of state or pending memory wait.
REQ-035 While in reset every output SHALL be 0, alu_op_o SHALL be AND and state_o SHALL be the IDLE encoding.
REQ-036 A pending memory request SHALL be abandoned on reset, and the first request after release SHALL be a fetch.

Structure
REQ-037 Opcodes, funct codes, ALU op codes, select encodings and the state enumeration SHALL reside in shared package mips_pkg.
REQ-038 funct-to-ALU-op decode SHALL be the sub-module alu_decoder, combinational and parametrised by ALU_OP_W.

Verification
REQ-039 ADD (opcode 0x00, funct 0x20), mem_ready_i=1 -> FETCH, DECODE, EXEC, ALUWB, FETCH; rd_en_o=1, rd_sel_o=1 for exactly 1 cycle.
REQ-040 LW (0x23) with mem_ready_i held 0 for 3 cycles in MEMREAD -> mem_req_o=1, iord_o=1 for 4 cycles; then MEMWB with rd_data_sel_o=1.
REQ-041 BEQ (0x04) with alu_zero_i=1 -> pc_we_o=1, pc_src_o=1 in BRANCH; with alu_zero_i=0 -> pc_we_o=0.
REQ-042 Opcode 0x3F -> illegal_o pulses 1 cycle in DECODE, no rd_en_o or mem_we_o, return to FETCH; J (0x02) with ENABLE_JUMP=0 -> same response.
REQ-043 SW (0x2B), rst_n_i dropped mid-MEMWRITE while mem_ready_i=0 -> outputs 0 immediately; after release, IDLE then FETCH with mem_we_o=0.
